fifo_bram_fwft: RTL and testbench

//  Single-clock synchronous FIFO on block RAM. DEPTH may be any integer >= 2, not only a power of 2.
//  Two read modes: standard (data 1 cycle after read) and first-word-fall-through (FWFT).

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_bram_fwft_bram.sv | 30 +++
 rtl/fifo_bram_fwft.sv | 178 +++++++++++++++++
 tb/tb_fifo_bram_fwft.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the block-RAM FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_bram_fwft_bram.sv
// Simple dual-port RAM: one write port, one read port with a registered read
// and no read enable. Contents are not reset.
module fifo_bram_fwft_bram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 6,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              i_wren,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port: commit data at the addressed entry.
  always_ff @(posedge clk) begin
    if (i_wren) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered read every cycle from the presented address.
  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fifo_bram_fwft.sv
// Single-clock FIFO on block RAM, any DEPTH >= 2, standard or first-word-
// fall-through read side. Occupancy and all flags derive from one counter.
module fifo_bram_fwft
  import fifo_pkg::*;
#(
  parameter int         DATA_W = 8,
  parameter int         DEPTH  = 6,
  parameter fifo_mode_e MODE   = FIFO_FWFT,
  parameter int         AF_THR = DEPTH - 1,
  parameter int         AE_THR = 1,
  localparam int        PTR_W  = $clog2(DEPTH),
  localparam int        CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_full,
  output logic              o_afull,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_empty,
  output logic              o_aempty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_ovf,
  output logic              o_udf
);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic              w_wr;
  logic              w_rd;
  logic              w_rd_adv;   // read pointer moves to the next entry
  logic              w_empty;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_raddr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              r_full;
  logic              r_afull;
  logic              r_aempty;
  logic              r_ovf;
  logic              r_udf;
  logic [DATA_W-1:0] w_ram_dout;

  // Flags are sampled at cycle start, so a same-cycle pop never unblocks a
  // write while full and a same-cycle push never unblocks a read while empty.
  assign w_wr = i_wren & ~r_full;
  assign w_rd = i_rden & ~w_empty;

  // Occupancy: +1 on write only, -1 on read only.
  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_rd) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_wr && w_rd) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // Shared pointer, count, registered flag and error-pulse state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_afull  <= (AF_THR == 0);
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count  <= w_count_next;
      r_full   <= (w_count_next == CNT_W'(DEPTH));
      r_afull  <= (w_count_next >= CNT_W'(AF_THR));
      r_aempty <= (w_count_next <= CNT_W'(AE_THR));
      r_ovf    <= i_wren & r_full;
      r_udf    <= i_rden & w_empty;
    end
  end

  assign o_full   = r_full;
  assign o_afull  = r_afull;
  assign o_aempty = r_aempty;
  assign o_count  = r_count;
  assign o_ovf    = r_ovf;
  assign o_udf    = r_udf;
  assign o_empty  = w_empty;

  fifo_bram_fwft_bram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_bram (
    .clk     (clk),
    .i_wren  (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_wrdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_dout)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // RAM output holds the entry at r_rd_ptr; it moves into the output
    // register when that register is empty or being popped.
    logic [CNT_W-1:0]  r_ram_cnt;   // entries in RAM not yet in output reg
    logic [CNT_W-1:0]  w_ram_left;
    logic              r_s1_valid;  // RAM output holds a committed entry
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              w_load;

    assign w_load     = r_s1_valid & (~r_out_valid | w_rd);
    assign w_rd_adv   = w_load;
    assign w_raddr    = w_load ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    // Entries at or past the new read address that were committed at an
    // earlier edge; only those may be flagged valid after this read.
    assign w_ram_left = r_ram_cnt - CNT_W'(w_load);

    // Prefetch pipeline bookkeeping.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_ram_cnt   <= '0;
        r_s1_valid  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        r_ram_cnt  <= w_ram_left + CNT_W'(w_wr);
        r_s1_valid <= (w_ram_left != '0);
        if (w_load) begin
          r_out_valid <= 1'b1;
        end else if (w_rd) begin
          r_out_valid <= 1'b0;
        end
      end
    end

    // Output data register, loaded from the RAM read port.
    always_ff @(posedge clk) begin
      if (w_load) begin
        r_out_data <= w_ram_dout;
      end
    end

    assign w_empty   = ~r_out_valid;
    assign o_rdvalid = r_out_valid;
    assign o_rddata  = r_out_data;
  end else begin : g_std
    logic r_rdvalid;

    assign w_rd_adv = w_rd;
    assign w_raddr  = r_rd_ptr;
    assign w_empty  = (r_count == '0);

    // Read-valid pulse for the cycle after an accepted read.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_rdvalid <= 1'b0;
      end else begin
        r_rdvalid <= w_rd;
      end
    end

    assign o_rdvalid = r_rdvalid;
    assign o_rddata  = w_ram_dout;
  end

endmodule

// File: tb/tb_fifo_bram_fwft.sv
// Randomised and directed bench for fifo_bram_fwft: one FWFT and one STD
// instance (DEPTH=6) checked against a queue-based reference model.
module tb_fifo_bram_fwft;
  import fifo_pkg::*;

  localparam int DEPTH = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  always #5 clk = ~clk;

  logic       f_wren = 0, f_rden = 0;
  logic [7:0] f_wrdata = '0, f_rddata;
  logic       f_full, f_afull, f_rdvalid, f_empty, f_aempty, f_ovf, f_udf;
  logic [2:0] f_count;

  logic       s_wren = 0, s_rden = 0;
  logic [7:0] s_wrdata = '0, s_rddata;
  logic       s_full, s_afull, s_rdvalid, s_empty, s_aempty, s_ovf, s_udf;
  logic [2:0] s_count;

  fifo_bram_fwft #(.DATA_W(8), .DEPTH(DEPTH), .MODE(FIFO_FWFT)) u_fwft (
    .clk(clk), .rstn(rstn), .i_wren(f_wren), .i_wrdata(f_wrdata),
    .o_full(f_full), .o_afull(f_afull), .i_rden(f_rden), .o_rddata(f_rddata),
    .o_rdvalid(f_rdvalid), .o_empty(f_empty), .o_aempty(f_aempty),
    .o_count(f_count), .o_ovf(f_ovf), .o_udf(f_udf));

  fifo_bram_fwft #(.DATA_W(8), .DEPTH(DEPTH), .MODE(FIFO_STD)) u_std (
    .clk(clk), .rstn(rstn), .i_wren(s_wren), .i_wrdata(s_wrdata),
    .o_full(s_full), .o_afull(s_afull), .i_rden(s_rden), .o_rddata(s_rddata),
    .o_rdvalid(s_rdvalid), .o_empty(s_empty), .o_aempty(s_aempty),
    .o_count(s_count), .o_ovf(s_ovf), .o_udf(s_udf));

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q_f[$];
  logic [7:0] q_s[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    f_wren = 0; f_rden = 0; s_wren = 0; s_rden = 0;
    rstn = 1'b0;
    @(posedge clk); #1;
    q_f.delete(); q_s.delete();
    chk("rst_f_count", f_count, 0);   chk("rst_f_empty", f_empty, 1);
    chk("rst_f_aempty", f_aempty, 1); chk("rst_f_full", f_full, 0);
    chk("rst_f_afull", f_afull, 0);   chk("rst_f_rdvalid", f_rdvalid, 0);
    chk("rst_f_pulses", {f_ovf, f_udf}, 0);
    chk("rst_s_count", s_count, 0);   chk("rst_s_empty", s_empty, 1);
    chk("rst_s_rdvalid", s_rdvalid, 0);
    chk("rst_s_pulses", {s_ovf, s_udf}, 0);
    $display("reset applied, both FIFOs empty");
    rstn = 1'b1;
  endtask

  // One FWFT cycle; caller only pops when the head is shown or model is empty.
  task automatic fwft_cycle(input logic wren, input logic [7:0] wdata, input logic rden);
    bit full_b, empty_b, wr_ok, rd_ok;
    if (!f_empty && q_f.size() > 0) chk("fwft_head", f_rddata, q_f[0]);
    full_b  = (q_f.size() == DEPTH);
    empty_b = (q_f.size() == 0);
    wr_ok   = wren && !full_b;
    rd_ok   = rden && !empty_b;
    f_wren = wren; f_wrdata = wdata; f_rden = rden;
    @(posedge clk); #1;
    f_wren = 0; f_rden = 0;
    if (rd_ok) void'(q_f.pop_front());
    if (wr_ok) q_f.push_back(wdata);
    chk("fwft_count", f_count, q_f.size());
    chk("fwft_full", f_full, q_f.size() == DEPTH);
    chk("fwft_afull", f_afull, q_f.size() >= DEPTH - 1);
    chk("fwft_aempty", f_aempty, q_f.size() <= 1);
    chk("fwft_ovf", f_ovf, wren && full_b);
    chk("fwft_udf", f_udf, rden && empty_b);
    if (q_f.size() == 0) chk("fwft_empty", f_empty, 1);
    $display("fwft wr=%0b d=%02h rd=%0b -> count=%0d empty=%0b head=%02h",
             wren, wdata, rden, f_count, f_empty, f_rddata);
  endtask

  // One STD cycle; every outcome is predicted exactly.
  task automatic std_cycle(input logic wren, input logic [7:0] wdata, input logic rden);
    bit full_b, empty_b, wr_ok, rd_ok;
    logic [7:0] exp_d;
    full_b  = (q_s.size() == DEPTH);
    empty_b = (q_s.size() == 0);
    wr_ok   = wren && !full_b;
    rd_ok   = rden && !empty_b;
    exp_d   = rd_ok ? q_s[0] : 8'h00;
    s_wren = wren; s_wrdata = wdata; s_rden = rden;
    @(posedge clk); #1;
    s_wren = 0; s_rden = 0;
    if (rd_ok) void'(q_s.pop_front());
    if (wr_ok) q_s.push_back(wdata);
    chk("std_rdvalid", s_rdvalid, rd_ok);
    if (rd_ok) chk("std_data", s_rddata, exp_d);
    chk("std_count", s_count, q_s.size());
    chk("std_empty", s_empty, q_s.size() == 0);
    chk("std_full", s_full, q_s.size() == DEPTH);
    chk("std_afull", s_afull, q_s.size() >= DEPTH - 1);
    chk("std_aempty", s_aempty, q_s.size() <= 1);
    chk("std_ovf", s_ovf, wren && full_b);
    chk("std_udf", s_udf, rden && empty_b);
    $display("std  wr=%0b d=%02h rd=%0b -> count=%0d rdvalid=%0b data=%02h",
             wren, wdata, rden, s_count, s_rdvalid, s_rddata);
  endtask

  task automatic fwft_drain();
    for (int k = 0; k < 40 && q_f.size() > 0; k++) fwft_cycle(1'b0, 8'h00, !f_empty);
    chk("fwft_drain_timeout", q_f.size(), 0);
  endtask

  initial begin
    do_reset();
    fwft_cycle(1'b0, 8'h00, 1'b0);
    std_cycle(1'b0, 8'h00, 1'b0);

    // Fill to full, then one write too many.
    for (int i = 0; i < 7; i++) fwft_cycle(1'b1, 8'h11 + 8'(i), 1'b0);
    // At full: simultaneous write and read -> read proceeds, write dropped.
    for (int k = 0; k < 5 && f_empty; k++) fwft_cycle(1'b0, 8'h00, 1'b0);
    fwft_cycle(1'b1, 8'h77, 1'b1);
    fwft_drain();
    // At empty: simultaneous write and read -> write proceeds, read ignored.
    fwft_cycle(1'b1, 8'h88, 1'b1);
    fwft_drain();

    // Fall-through latency of a single write into an empty FIFO.
    fwft_cycle(1'b1, 8'hA5, 1'b0);
    chk("a5_after_E", f_empty, 1);
    fwft_cycle(1'b0, 8'h00, 1'b0);
    chk("a5_after_E1", f_empty, 1);
    fwft_cycle(1'b0, 8'h00, 1'b0);
    chk("a5_after_E2_empty", f_empty, 0);
    chk("a5_after_E2_data", f_rddata, 8'hA5);
    fwft_cycle(1'b0, 8'h00, 1'b1);
    chk("a5_pop_empty", f_empty, 1);

    // STD: four writes, four back-to-back reads, one read too many.
    for (int i = 1; i <= 4; i++) std_cycle(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) std_cycle(1'b0, 8'h00, 1'b1);

    // Interleaved traffic with three entries in flight, several wraps.
    for (int i = 0; i < 20; i++) std_cycle(1'b1, 8'h40 + 8'(i), q_s.size() >= 3);
    for (int i = 0; i < 4; i++) std_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++)
      fwft_cycle(1'b1, 8'h60 + 8'(i), q_f.size() >= 3 && !f_empty);
    fwft_drain();

    // Random traffic on both modes.
    for (int i = 0; i < 300; i++)
      fwft_cycle($urandom_range(0, 99) < 55, 8'($urandom),
                 (!f_empty || q_f.size() == 0) && $urandom_range(0, 99) < 50);
    fwft_drain();
    for (int i = 0; i < 300; i++)
      std_cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);

    // Reset with four entries held mid-stream; old data must not return.
    while (q_s.size() > 0) std_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      std_cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
      fwft_cycle(1'b1, 8'hD0 + 8'(i), 1'b0);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      std_cycle(1'b0, 8'h00, 1'b1);
      fwft_cycle(1'b0, 8'h00, 1'b0);
    end
    std_cycle(1'b1, 8'h5A, 1'b0);
    std_cycle(1'b0, 8'h00, 1'b1);
    fwft_cycle(1'b1, 8'h5B, 1'b0);
    fwft_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
